pacman_soc_onchip_memory_arbiter: RTL

- Two-requester round-robin arbiter sharing the single-port 32K x 32 on-chip RAM.
- Requester 0 is the CPU data master; requester 1 is the video/sprite fetch master.
- Presents an Avalon-MM slave with waitrequest/readdatavalid to each master.
- Drives the RAM's address/byteenable/chipselect/write/writedata/clken port. The RAM has 1-cycle read latency: address is registered, q is unregistered.

---
 rtl/pacman_soc_onchip_memory_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/pacman_soc_onchip_memory_arbiter.sv
// Round-robin arbiter letting the CPU data master (m0) and the video fetch master (m1)
// share one single-port on-chip RAM with 1-cycle read latency.
module pacman_soc_onchip_memory_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic req_0, req_1;
    logic gnt_0, gnt_1;
    logic rd_acc;
    logic last_gnt, rd_pend, rd_owner;

    assign req_0 = m0_read | m0_write;
    assign req_1 = m1_read | m1_write;

    // On contention the requester that did not win last time is served.
    assign gnt_0 = req_0 & (~req_1 | last_gnt);
    assign gnt_1 = req_1 & (~req_0 | ~last_gnt);

    assign m0_waitrequest = ~gnt_0;
    assign m1_waitrequest = ~gnt_1;

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        if (gnt_0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_write      = m0_write;
        end else if (gnt_1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end
    end

    assign mem_chipselect = gnt_0 | gnt_1;
    assign mem_clken      = 1'b1;

    // Read+write together is treated as a write, so it never produces read data.
    assign rd_acc = (gnt_0 & m0_read & ~m0_write) | (gnt_1 & m1_read & ~m1_write);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (gnt_0 | gnt_1) begin
                last_gnt <= gnt_1;
            end
            rd_pend <= rd_acc;
            if (rd_acc) begin
                rd_owner <= gnt_1;
            end
        end
    end

    assign m0_readdatavalid = rd_pend & ~rd_owner;
    assign m1_readdatavalid = rd_pend & rd_owner;
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule
